// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_pkg
// Description : Shared types and constants for the instruction-memory path:
//               responder FSM state encoding, instruction width, opcode
//               field bounds and the data value returned on a fault.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    localparam int INSTR_W   = 32;
    localparam int OPCODE_HI = 31;
    localparam int OPCODE_LO = 26;
    localparam int OPCODE_W  = OPCODE_HI - OPCODE_LO + 1;

    // Data driven on rsp_data whenever a response carries rsp_err=1
    localparam logic [INSTR_W-1:0] ERR_DATA = '0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage : cpu_pkg
`default_nettype wire

// File: rtl/imem_array.sv
`default_nettype none
// ============================================================================
// Module      : imem_array
// Description : Word-organised instruction store. Synchronous write,
//               combinational read. Contents are deliberately not reset so a
//               loaded program survives a responder reset.
// Ports       : clk    - clock
//               we     - write enable (already qualified by the caller)
//               waddr  - write word index
//               wdata  - write data
//               raddr  - read word index
//               rdata  - read data (combinational)
// Revision    : 1.0 - initial release
// ============================================================================
module imem_array
    import cpu_pkg::*;
#(
    parameter int DEPTH_WORDS = 64,
    parameter int ADDR_W      = $clog2(DEPTH_WORDS)
) (
    input  logic               clk,
    input  logic               we,
    input  logic [ADDR_W-1:0]  waddr,
    input  logic [INSTR_W-1:0] wdata,
    input  logic [ADDR_W-1:0]  raddr,
    output logic [INSTR_W-1:0] rdata
);

    logic [INSTR_W-1:0] r_mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata = r_mem[raddr];

endmodule : imem_array
`default_nettype wire

// File: rtl/imem_responder.sv
`default_nettype none
// ============================================================================
// Module      : imem_responder
// Description : Instruction-fetch responder with a fixed number of wait
//               states. One request outstanding at a time; misaligned or
//               out-of-range fetches return ERR_DATA with rsp_err set after
//               the same latency as a good fetch. A program-load port writes
//               the array while the responder is idle.
// Ports       : clk                - clock, rising edge
//               rst_n              - synchronous active-low reset
//               req_valid/req_addr - fetch request (byte address)
//               req_ready          - request accepted this cycle when high
//               rsp_valid/rsp_data/rsp_err - response, held until rsp_ready
//               rsp_ready          - response handshake from the CPU
//               opcode             - opcode field of last accepted response
//               load_en/load_addr/load_data - program-load write port
// Revision    : 1.0 - initial release
// ============================================================================
module imem_responder
    import cpu_pkg::*;
#(
    parameter int DEPTH_WORDS = 64,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    input  logic [INSTR_W-1:0]  req_addr,
    output logic                req_ready,
    output logic                rsp_valid,
    output logic [INSTR_W-1:0]  rsp_data,
    output logic                rsp_err,
    input  logic                rsp_ready,
    output logic [OPCODE_W-1:0] opcode,
    input  logic                load_en,
    input  logic [INSTR_W-1:0]  load_addr,
    input  logic [INSTR_W-1:0]  load_data
);

    localparam int         c_addr_w   = $clog2(DEPTH_WORDS);
    // Counter preload; with no wait states the WAIT state is never entered
    localparam logic [3:0] c_cnt_init = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [3:0]            r_cnt;
    logic [3:0]            w_cnt_nxt;
    logic [c_addr_w-1:0]   r_idx;
    logic                  r_err;
    logic [OPCODE_W-1:0]   r_opcode;

    logic                  w_accept;
    logic                  w_req_bad;
    logic                  w_load_ok;
    logic                  w_we;
    logic [INSTR_W-1:0]    w_rdata;

    // A word index beyond the array is a fault, never a wrap-around
    assign w_req_bad = (req_addr[1:0] != 2'b00)
                     || (req_addr[INSTR_W-1:2] >= 30'(DEPTH_WORDS));
    assign w_load_ok = (load_addr[1:0] == 2'b00)
                     && (load_addr[INSTR_W-1:2] < 30'(DEPTH_WORDS));

    assign w_accept  = (r_state == ST_IDLE) && req_valid;
    // Reset outranks a load in the same cycle
    assign w_we      = rst_n && (r_state == ST_IDLE) && load_en && w_load_ok;

    imem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .ADDR_W      (c_addr_w)
    ) u_array (
        .clk   (clk),
        .we    (w_we),
        .waddr (load_addr[c_addr_w+1:2]),
        .wdata (load_data),
        .raddr (r_idx),
        .rdata (w_rdata)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (req_valid) begin
                    w_state_nxt = (WAIT_CYCLES == 0) ? ST_RESP : ST_WAIT;
                    w_cnt_nxt   = c_cnt_init;
                end
            end
            ST_WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_state_nxt = ST_RESP;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_cnt    <= 4'd0;
            r_idx    <= '0;
            r_err    <= 1'b0;
            r_opcode <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_accept) begin
                r_idx <= req_addr[c_addr_w+1:2];
                r_err <= w_req_bad;
            end
            if ((r_state == ST_RESP) && rsp_ready) begin
                r_opcode <= rsp_data[OPCODE_HI:OPCODE_LO];
            end
        end
    end

    // The array cannot be written outside IDLE, so a combinational read of
    // the latched index stays stable for the whole RESP phase and already
    // reflects a load that landed on the accepting edge.
    assign req_ready = (r_state == ST_IDLE);
    assign rsp_valid = (r_state == ST_RESP);
    assign rsp_err   = (r_state == ST_RESP) && r_err;
    assign rsp_data  = ((r_state == ST_RESP) && !r_err) ? w_rdata : ERR_DATA;
    assign opcode    = r_opcode;

endmodule : imem_responder
`default_nettype wire

// File: tb/tb_imem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_imem_responder
// Description : Directed self-checking bench for imem_responder. Instance
//               dut uses the default two wait states; dut0 is built with
//               no wait states.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_imem_responder;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        req_valid, req_ready, rsp_valid, rsp_err, rsp_ready, load_en;
    logic [31:0] req_addr, rsp_data, load_addr, load_data;
    logic [5:0]  opcode;

    logic        req_valid0, req_ready0, rsp_valid0, rsp_err0, rsp_ready0, load_en0;
    logic [31:0] req_addr0, rsp_data0, load_addr0, load_data0;
    logic [5:0]  opcode0;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    imem_responder #(.DEPTH_WORDS(64), .WAIT_CYCLES(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .rsp_ready(rsp_ready), .opcode(opcode),
        .load_en(load_en), .load_addr(load_addr), .load_data(load_data)
    );

    imem_responder #(.DEPTH_WORDS(64), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid0), .req_addr(req_addr0), .req_ready(req_ready0),
        .rsp_valid(rsp_valid0), .rsp_data(rsp_data0), .rsp_err(rsp_err0),
        .rsp_ready(rsp_ready0), .opcode(opcode0),
        .load_en(load_en0), .load_addr(load_addr0), .load_data(load_data0)
    );

    // Advance one rising edge and settle just past it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_word(input logic [31:0] a, input logic [31:0] d);
        load_en = 1'b1; load_addr = a; load_data = d;
        tick();
        load_en = 1'b0;
    endtask

    // Issue a request with rsp_ready low; returns once rsp_valid is seen
    // (or after a cycle budget). lat = cycles from accepting edge.
    task automatic fetch(input logic [31:0] a, output int lat);
        req_valid = 1'b1; req_addr = a; rsp_ready = 1'b0;
        tick();
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 20) begin
            tick();
            lat++;
        end
    endtask

    task automatic handshake();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL reset_req_ready got %b want 1", req_ready); end
        n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); end
        n_cmp++; if (rsp_data !== 32'h0) begin n_bad++; $display("FAIL reset_rsp_data got %h want 0", rsp_data); end
        n_cmp++; if (rsp_err !== 1'b0) begin n_bad++; $display("FAIL reset_rsp_err got %b want 0", rsp_err); end
        n_cmp++; if (opcode !== 6'h0) begin n_bad++; $display("FAIL reset_opcode got %h want 0", opcode); end
        n_cmp++; if (req_ready0 !== 1'b1 || rsp_valid0 !== 1'b0) begin n_bad++; $display("FAIL reset_dut0 got rdy=%b vld=%b want 1/0", req_ready0, rsp_valid0); end
    endtask

    task automatic test_basic_fetch();
        int lat;
        load_word(32'h0, 32'h8C01_0004);
        load_word(32'h8, 32'hFC00_0001);
        fetch(32'h0, lat);
        n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL fetch0_latency got %0d want 3", lat); end
        n_cmp++; if (rsp_data !== 32'h8C01_0004) begin n_bad++; $display("FAIL fetch0_data got %h want 8c010004", rsp_data); end
        n_cmp++; if (rsp_err !== 1'b0) begin n_bad++; $display("FAIL fetch0_err got %b want 0", rsp_err); end
        n_cmp++; if (opcode !== 6'h0) begin n_bad++; $display("FAIL fetch0_opcode_before got %h want 0", opcode); end
        handshake();
        n_cmp++; if (opcode !== 6'h23) begin n_bad++; $display("FAIL fetch0_opcode got %h want 23", opcode); end
        n_cmp++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin n_bad++; $display("FAIL fetch0_idle got rdy=%b vld=%b want 1/0", req_ready, rsp_valid); end
        fetch(32'h8, lat);
        n_cmp++; if (rsp_data !== 32'hFC00_0001 || rsp_err !== 1'b0) begin n_bad++; $display("FAIL fetch8 got %h/%b want fc000001/0", rsp_data, rsp_err); end
        handshake();
        n_cmp++; if (opcode !== 6'h3F) begin n_bad++; $display("FAIL fetch8_opcode got %h want 3f", opcode); end
    endtask

    task automatic test_errors();
        int lat;
        fetch(32'h2, lat);
        n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL misalign_latency got %0d want 3", lat); end
        n_cmp++; if (rsp_err !== 1'b1 || rsp_data !== 32'h0) begin n_bad++; $display("FAIL misalign got %h/%b want 0/1", rsp_data, rsp_err); end
        handshake();
        n_cmp++; if (opcode !== 6'h0) begin n_bad++; $display("FAIL misalign_opcode got %h want 0", opcode); end
        fetch(32'h100, lat);
        n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL oor_latency got %0d want 3", lat); end
        n_cmp++; if (rsp_err !== 1'b1 || rsp_data !== 32'h0) begin n_bad++; $display("FAIL oor_100 got %h/%b want 0/1", rsp_data, rsp_err); end
        handshake();
        fetch(32'h8000_0000, lat);
        n_cmp++; if (rsp_err !== 1'b1 || rsp_data !== 32'h0) begin n_bad++; $display("FAIL oor_high got %h/%b want 0/1", rsp_data, rsp_err); end
        handshake();
        load_word(32'hFC, 32'h1234_5678);
        fetch(32'hFC, lat);
        n_cmp++; if (rsp_err !== 1'b0 || rsp_data !== 32'h1234_5678) begin n_bad++; $display("FAIL last_word got %h/%b want 12345678/0", rsp_data, rsp_err); end
        handshake();
    endtask

    task automatic test_stall();
        int lat;
        fetch(32'h2, lat);
        handshake();
        fetch(32'h0, lat);
        req_valid = 1'b1; req_addr = 32'h8;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_cmp++; if (rsp_valid !== 1'b1) begin n_bad++; $display("FAIL stall_valid[%0d] got %b want 1", i, rsp_valid); end
            n_cmp++; if (rsp_data !== 32'h8C01_0004) begin n_bad++; $display("FAIL stall_data[%0d] got %h want 8c010004", i, rsp_data); end
            n_cmp++; if (req_ready !== 1'b0) begin n_bad++; $display("FAIL stall_req_ready[%0d] got %b want 0", i, req_ready); end
            n_cmp++; if (opcode !== 6'h0) begin n_bad++; $display("FAIL stall_opcode[%0d] got %h want 0", i, opcode); end
        end
        req_valid = 1'b0;
        handshake();
        n_cmp++; if (opcode !== 6'h23) begin n_bad++; $display("FAIL stall_opcode_after got %h want 23", opcode); end
        n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL stall_no_dup got %b want 0", rsp_valid); end
    endtask

    task automatic test_reset_in_wait();
        int lat;
        req_valid = 1'b1; req_addr = 32'h0;
        tick();
        req_valid = 1'b0;
        tick();
        // Reset alongside a load and a request: both must be ignored
        rst_n = 1'b0; load_en = 1'b1; load_addr = 32'h0; load_data = 32'hFFFF_FFFF;
        req_valid = 1'b1;
        tick();
        rst_n = 1'b1; load_en = 1'b0; req_valid = 1'b0;
        n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL rstwait_req_ready got %b want 1", req_ready); end
        n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL rstwait_rsp_valid got %b want 0", rsp_valid); end
        n_cmp++; if (opcode !== 6'h0) begin n_bad++; $display("FAIL rstwait_opcode got %h want 0", opcode); end
        for (int i = 0; i < 6; i++) begin
            tick();
            n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL rstwait_stale[%0d] got %b want 0", i, rsp_valid); end
        end
        fetch(32'h0, lat);
        n_cmp++; if (rsp_data !== 32'h8C01_0004) begin n_bad++; $display("FAIL rstwait_mem_kept got %h want 8c010004", rsp_data); end
        handshake();
    endtask

    task automatic test_load();
        int lat;
        load_word(32'h4, 32'h1111_2222);
        load_en = 1'b1; load_addr = 32'h4; load_data = 32'h0;
        req_valid = 1'b1; req_addr = 32'h4; rsp_ready = 1'b0;
        tick();
        load_en = 1'b0; req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 20) begin tick(); lat++; end
        n_cmp++; if (rsp_data !== 32'h0 || rsp_err !== 1'b0) begin n_bad++; $display("FAIL same_cycle_load got %h/%b want 0/0", rsp_data, rsp_err); end
        handshake();
        // Load during WAIT/RESP must not land
        req_valid = 1'b1; req_addr = 32'h8;
        tick();
        req_valid = 1'b0;
        load_en = 1'b1; load_addr = 32'h8; load_data = 32'hAAAA_AAAA;
        tick(); tick();
        n_cmp++; if (rsp_valid !== 1'b1 || rsp_data !== 32'hFC00_0001) begin n_bad++; $display("FAIL load_in_wait got %b/%h want 1/fc000001", rsp_valid, rsp_data); end
        load_en = 1'b0;
        handshake();
        fetch(32'h8, lat);
        n_cmp++; if (rsp_data !== 32'hFC00_0001) begin n_bad++; $display("FAIL load_in_wait_mem got %h want fc000001", rsp_data); end
        handshake();
        load_word(32'h5, 32'hDEAD_BEEF);
        load_word(32'h100, 32'hDEAD_BEEF);
        fetch(32'h4, lat);
        n_cmp++; if (rsp_data !== 32'h0) begin n_bad++; $display("FAIL misaligned_load got %h want 0", rsp_data); end
        handshake();
        fetch(32'h0, lat);
        n_cmp++; if (rsp_data !== 32'h8C01_0004) begin n_bad++; $display("FAIL oor_load_wrap got %h want 8c010004", rsp_data); end
        handshake();
    endtask

    task automatic test_wait0();
        int acc;
        int hs;
        load_en0 = 1'b1; load_addr0 = 32'h4; load_data0 = 32'h5555_AAAA;
        req_valid0 = 1'b1; req_addr0 = 32'h4; rsp_ready0 = 1'b0;
        tick();
        load_en0 = 1'b0; req_valid0 = 1'b0;
        n_cmp++; if (rsp_valid0 !== 1'b1 || rsp_data0 !== 32'h5555_AAAA || rsp_err0 !== 1'b0) begin n_bad++; $display("FAIL w0_same_cycle got %b/%h/%b want 1/5555aaaa/0", rsp_valid0, rsp_data0, rsp_err0); end
        rsp_ready0 = 1'b1;
        tick();
        rsp_ready0 = 1'b0;
        n_cmp++; if (opcode0 !== 6'h15) begin n_bad++; $display("FAIL w0_opcode1 got %h want 15", opcode0); end
        load_en0 = 1'b1; load_addr0 = 32'h0; load_data0 = 32'h8C01_0004;
        tick();
        load_en0 = 1'b0;
        acc = 0; hs = 0;
        req_valid0 = 1'b1; req_addr0 = 32'h0; rsp_ready0 = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (req_valid0 && req_ready0) acc++;
            if (rsp_valid0 && rsp_ready0) hs++;
            tick();
            n_cmp++; if (rsp_valid0 !== ((i % 2) == 0)) begin n_bad++; $display("FAIL w0_rsp_valid[%0d] got %b want %b", i, rsp_valid0, ((i % 2) == 0)); end
            if ((i % 2) == 0) begin
                n_cmp++; if (rsp_data0 !== 32'h8C01_0004) begin n_bad++; $display("FAIL w0_data[%0d] got %h want 8c010004", i, rsp_data0); end
            end
        end
        req_valid0 = 1'b0; rsp_ready0 = 1'b0;
        n_cmp++; if (acc !== 4) begin n_bad++; $display("FAIL w0_accepts got %0d want 4", acc); end
        n_cmp++; if (hs !== 4) begin n_bad++; $display("FAIL w0_handshakes got %0d want 4", hs); end
        n_cmp++; if (opcode0 !== 6'h23) begin n_bad++; $display("FAIL w0_opcode2 got %h want 23", opcode0); end
    endtask

    initial begin
        rst_n = 1'b0;
        req_valid = 1'b0; req_addr = '0; rsp_ready = 1'b0;
        load_en = 1'b0; load_addr = '0; load_data = '0;
        req_valid0 = 1'b0; req_addr0 = '0; rsp_ready0 = 1'b0;
        load_en0 = 1'b0; load_addr0 = '0; load_data0 = '0;
        test_reset();
        test_basic_fetch();
        test_errors();
        test_stall();
        test_reset_in_wait();
        test_load();
        test_wait0();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_imem_responder
`default_nettype wire
